// File: rtl/ram_master_pkg.sv
// Shared types and sizing constants for the RAM port master.
// Default width values are used by the top when no override is given.
package ram_master_pkg;

    localparam int DATA_W = 32;
    localparam int BW     = DATA_W / 8;
    localparam int OFFS_W = $clog2(BW);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MERGE,
        WRITE,
        RESP
    } state_e;

endpackage

// File: rtl/ram_port_master_byte_merge.sv
// Byte-lane merge: lanes with be=1 take the new word, all other lanes keep the old word.
// Lets sub-word stores work on a RAM that has no byte enables.
module byte_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   old_word,
    input  logic [DW-1:0]   new_word,
    input  logic [DW/8-1:0] be,
    output logic [DW-1:0]   merged
);

    always_comb begin
        // NOTE: assign a full default first so no path through the loop can infer a latch.
        merged = old_word;
        for (int i = 0; i < DW / 8; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_port_master.sv
// Initiator for a single-port data RAM. Takes load/store requests one at a time.
// Sub-word stores are done as read-modify-write. Each request gets exactly one response.
module ram_port_master
    import ram_master_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic [AW-1:0]   mem_a,
    output logic [DW-1:0]   mem_wd,
    output logic            mem_we,
    input  logic [DW-1:0]   mem_rd
);

    localparam int LBW = DW / 8;

    state_e          state_q,     state_d;
    logic [AW-1:0]   addr_q,      addr_d;
    logic [DW-1:0]   word_q,      word_d;
    logic [LBW-1:0]  be_q,        be_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q,   rsp_err_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic            misaligned;
    logic [DW-1:0]   merged;

    assign misaligned = (req_addr & AW'(LBW - 1)) != '0;

    byte_merge #(.DW(DW)) u_byte_merge (
        .old_word (mem_rd),
        .new_word (word_q),
        .be       (be_q),
        .merged   (merged)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_d      = word_q;
        be_d        = be_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    word_d      = req_wdata;
                    be_d        = req_be;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    // Errors and empty stores answer at once and never touch the RAM.
                    if (misaligned) begin
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else if (req_we && req_be == '0) begin
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else if (req_we && (&req_be)) begin
                        state_d = WRITE;
                    end else if (req_we) begin
                        state_d = MERGE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                rsp_rdata_d = mem_rd;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            MERGE: begin
                word_d  = merged;
                state_d = WRITE;
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            word_q      <= '0;
            be_q        <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            be_q        <= be_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // NOTE: mem_we is a pure state decode, so the asynchronous reset of state_q kills a pending write.
    assign mem_we    = (state_q == WRITE);
    assign mem_a     = (state_q inside {LOAD, MERGE, WRITE}) ? addr_q : '0;
    assign mem_wd    = mem_we ? word_q : '0;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master with a behavioural 16-word RAM behind the memory port.
// Covers reset, loads, full and partial stores, errors, backpressure and reset mid-merge.
module tb_ram_port_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] ram [0:15] = '{default: 32'h0};
    logic        pl_en   = 1'b0;
    logic [3:0]  pl_idx  = '0;
    logic [31:0] pl_data = '0;
    int          we_cnt  = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    int checks = 0;
    int errors = 0;
    int w0;

    always #5 clk = ~clk;

    ram_port_master #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd)
    );

    assign mem_rd = ram[mem_a[5:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_idx] <= pl_data;
        end else if (mem_we) begin
            ram[mem_a[5:2]] <= mem_wd;
            we_cnt  <= we_cnt + 1;
            last_wa <= mem_a;
            last_wd <= mem_wd;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        tick();
        pl_en   = 1'b0;
    endtask

    // Presents one request and returns just after its acceptance edge.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;

        preload(4'd2, 32'hAABBCCDD);
        preload(4'd3, 32'h11223344);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_mem_we",    {31'b0, mem_we},    32'd0);
        check("rst_mem_a",     mem_a,              32'h0);
        check("rst_rdata",     rsp_rdata,          32'h0);
        check("rst_err",       {31'b0, rsp_err},   32'd0);
        check("rst_ram4",      ram[1],             32'h0);
        rst = 1'b1;
        tick();

        // Full-word store: single write cycle, response two cycles after acceptance.
        w0 = we_cnt;
        send(1'b1, 32'h4, 32'h100, 4'hF);
        check("fst_mem_we", {31'b0, mem_we}, 32'd1);
        check("fst_mem_a",  mem_a,           32'h4);
        check("fst_mem_wd", mem_wd,          32'h100);
        wait_rsp("fst", 2);
        check("fst_err",    {31'b0, rsp_err}, 32'd0);
        check("fst_rdata",  rsp_rdata,        32'h0);
        check("fst_we_cnt", 32'(we_cnt - w0), 32'd1);
        check("fst_wa",     last_wa,          32'h4);
        check("fst_wd",     last_wd,          32'h100);
        tick();

        send(1'b0, 32'h4, 32'h0, 4'h0);
        wait_rsp("ld4", 2);
        check("ld4_rdata", rsp_rdata,        32'h100);
        check("ld4_err",   {31'b0, rsp_err}, 32'd0);
        tick();

        // Partial store: only byte lane 1 replaced.
        w0 = we_cnt;
        send(1'b1, 32'h8, 32'h0000_1100, 4'b0010);
        wait_rsp("pst", 3);
        check("pst_ram8",   ram[2],           32'hAABB11DD);
        check("pst_we_cnt", 32'(we_cnt - w0), 32'd1);
        check("pst_err",    {31'b0, rsp_err}, 32'd0);
        tick();

        w0 = we_cnt;
        send(1'b0, 32'h6, 32'h0, 4'h0);
        wait_rsp("mis", 1);
        check("mis_err",    {31'b0, rsp_err}, 32'd1);
        check("mis_rdata",  rsp_rdata,        32'h0);
        check("mis_we_cnt", 32'(we_cnt - w0), 32'd0);
        tick();

        w0 = we_cnt;
        send(1'b1, 32'h4, 32'hFFFF_FFFF, 4'h0);
        wait_rsp("be0", 1);
        check("be0_err",    {31'b0, rsp_err}, 32'd0);
        check("be0_rdata",  rsp_rdata,        32'h0);
        check("be0_we_cnt", 32'(we_cnt - w0), 32'd0);
        check("be0_ram4",   ram[1],           32'h100);
        tick();

        // Backpressure: response must hold while a competing request is offered.
        w0 = we_cnt;
        rsp_ready = 1'b0;
        send(1'b0, 32'h8, 32'h0, 4'h0);
        wait_rsp("bp", 2);
        check("bp_rdata0", rsp_rdata, 32'hAABB11DD);
        req_we    = 1'b1;
        req_addr  = 32'h4;
        req_wdata = 32'hDEAD_BEEF;
        req_be    = 4'hF;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid",     {31'b0, rsp_valid}, 32'd1);
            check("bp_rdata",     rsp_rdata,          32'hAABB11DD);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_idle",      {31'b0, req_ready}, 32'd1);
        check("bp_rsp_clear", {31'b0, rsp_valid}, 32'd0);
        check("bp_we_cnt",    32'(we_cnt - w0),   32'd0);
        check("bp_ram4",      ram[1],             32'h100);

        // Reset while the partial store to 0xC is in its merge cycle.
        w0 = we_cnt;
        send(1'b1, 32'hC, 32'h0000_00FF, 4'b0001);
        check("rm_mem_a", mem_a, 32'hC);
        rst = 1'b0;
        #1;
        check("rm_req_ready", {31'b0, req_ready}, 32'd1);
        check("rm_mem_we",    {31'b0, mem_we},    32'd0);
        check("rm_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rm_ramC",    ram[3],             32'h11223344);
        check("rm_we_cnt",  32'(we_cnt - w0),   32'd0);
        check("rm_idle",    {31'b0, req_ready}, 32'd1);
        check("rm_no_rsp",  {31'b0, rsp_valid}, 32'd0);

        send(1'b0, 32'hC, 32'h0, 4'h0);
        wait_rsp("ldC", 2);
        check("ldC_rdata", rsp_rdata, 32'h11223344);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
